// File: rtl/multicycle_control_fsm.sv
// Multi-cycle, non-pipelined control unit sitting behind the fetch/PC unit.
// One instruction in flight: FETCH -> DECODE -> {EXEC [-> MEM] [-> WB] | BRANCH | HALT}.
module multicycle_control_fsm #(
    parameter logic ILLEGAL_HALT = 1'b1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        ALU_zero,
    output logic        PC_Reset,
    output logic        PC_LdEn,
    output logic        PC_sel,
    output logic [31:0] PC_Immed,
    output logic [31:0] IR,
    output logic [31:0] Immed,
    output logic        RF_WrEn,
    output logic        RF_WrDst_sel,
    output logic        RF_WrData_sel,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        MEM_WrEn,
    output logic        Illegal,
    output logic [2:0]  State
);

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_BRANCH = 3'd6,
        ST_HALT   = 3'd7
    } state_t;

    typedef enum logic [2:0] {
        OP_RTYPE = 3'd0,
        OP_ADDI  = 3'd1,
        OP_LW    = 3'd2,
        OP_SW    = 3'd3,
        OP_BEQ   = 3'd4,
        OP_B     = 3'd5,
        OP_ILL   = 3'd6
    } op_t;

    localparam logic [5:0] OPC_RTYPE = 6'b000000;
    localparam logic [5:0] OPC_ADDI  = 6'b001000;
    localparam logic [5:0] OPC_LW    = 6'b100011;
    localparam logic [5:0] OPC_SW    = 6'b101011;
    localparam logic [5:0] OPC_BEQ   = 6'b000100;
    localparam logic [5:0] OPC_B     = 6'b000010;

    function automatic op_t decode_op(input logic [5:0] opcode, input logic [5:0] funct);
        op_t op;
        case (opcode)
            OPC_RTYPE: op = (funct[5:4] == 2'b10) ? OP_RTYPE : OP_ILL;
            OPC_ADDI:  op = OP_ADDI;
            OPC_LW:    op = OP_LW;
            OPC_SW:    op = OP_SW;
            OPC_BEQ:   op = OP_BEQ;
            OPC_B:     op = OP_B;
            default:   op = OP_ILL;
        endcase
        return op;
    endfunction

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    // ALU operation for the execute-side states; R-type carries its own code in funct[3:0]
    function automatic logic [3:0] exec_alu_func(input op_t op, input logic [3:0] funct_lo);
        logic [3:0] f;
        case (op)
            OP_RTYPE: f = funct_lo;
            OP_BEQ:   f = 4'b0001;
            default:  f = 4'b0000;
        endcase
        return f;
    endfunction

    function automatic logic exec_bin_sel(input op_t op);
        logic b;
        case (op)
            OP_ADDI, OP_LW, OP_SW: b = 1'b1;
            default:               b = 1'b0;
        endcase
        return b;
    endfunction

    state_t      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] immed_q, immed_d;
    logic [31:0] pc_immed_q, pc_immed_d;
    logic        illegal_q, illegal_d;
    op_t         instr_op_s;
    op_t         ir_op_s;

    assign instr_op_s = decode_op(Instr[31:26], Instr[5:0]);
    assign ir_op_s    = decode_op(ir_q[31:26], ir_q[5:0]);

    // State and instruction registers; async reset returns straight to INIT
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q    <= ST_INIT;
            ir_q       <= 32'h0000_0000;
            immed_q    <= 32'h0000_0000;
            pc_immed_q <= 32'h0000_0000;
            illegal_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            ir_q       <= ir_d;
            immed_q    <= immed_d;
            pc_immed_q <= pc_immed_d;
            illegal_q  <= illegal_d;
        end
    end

    // Next-state logic and instruction capture at the end of DECODE
    always_comb begin
        state_d    = state_q;
        ir_d       = ir_q;
        immed_d    = immed_q;
        pc_immed_d = pc_immed_q;
        illegal_d  = illegal_q;
        case (state_q)
            ST_INIT:  state_d = ST_FETCH;
            ST_FETCH: state_d = ST_DECODE;
            ST_DECODE: begin
                ir_d       = Instr;
                immed_d    = sext16(Instr[15:0]);
                pc_immed_d = {immed_d[29:0], 2'b00};
                case (instr_op_s)
                    OP_RTYPE, OP_ADDI, OP_LW, OP_SW: state_d = ST_EXEC;
                    OP_BEQ, OP_B:                    state_d = ST_BRANCH;
                    default: begin
                        // the flag records every illegal word, even when it is retired as a NOP
                        illegal_d = 1'b1;
                        if (ILLEGAL_HALT == 1'b1) begin
                            state_d = ST_HALT;
                        end else begin
                            state_d = ST_BRANCH;
                        end
                    end
                endcase
            end
            ST_EXEC: begin
                if (ir_op_s == OP_LW || ir_op_s == OP_SW) begin
                    state_d = ST_MEM;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (ir_op_s == OP_LW) begin
                    state_d = ST_WB;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_WB:     state_d = ST_FETCH;
            ST_BRANCH: state_d = ST_FETCH;
            ST_HALT:   state_d = ST_HALT;
            default:   state_d = ST_INIT;
        endcase
    end

    // Moore decode of state and IR; ALU_zero -> PC_sel is the only input-to-output path
    always_comb begin
        PC_Reset      = 1'b0;
        PC_LdEn       = 1'b0;
        PC_sel        = 1'b0;
        RF_WrEn       = 1'b0;
        RF_WrDst_sel  = 1'b0;
        RF_WrData_sel = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = 4'b0000;
        MEM_WrEn      = 1'b0;
        PC_Immed      = pc_immed_q;
        IR            = ir_q;
        Immed         = immed_q;
        Illegal       = illegal_q;
        State         = state_q;
        case (state_q)
            ST_INIT: PC_Reset = 1'b1;
            ST_FETCH, ST_DECODE, ST_HALT: begin
            end
            ST_EXEC: begin
                ALU_func    = exec_alu_func(ir_op_s, ir_q[3:0]);
                ALU_Bin_sel = exec_bin_sel(ir_op_s);
            end
            ST_MEM: begin
                ALU_func    = exec_alu_func(ir_op_s, ir_q[3:0]);
                ALU_Bin_sel = exec_bin_sel(ir_op_s);
                if (ir_op_s == OP_SW) begin
                    MEM_WrEn = 1'b1;
                    PC_LdEn  = 1'b1;
                end else begin
                    MEM_WrEn = 1'b0;
                    PC_LdEn  = 1'b0;
                end
            end
            ST_WB: begin
                // ALU controls stay stable so the result being written does not move
                ALU_func      = exec_alu_func(ir_op_s, ir_q[3:0]);
                ALU_Bin_sel   = exec_bin_sel(ir_op_s);
                RF_WrEn       = 1'b1;
                RF_WrDst_sel  = (ir_op_s == OP_RTYPE);
                RF_WrData_sel = (ir_op_s == OP_LW);
                PC_LdEn       = 1'b1;
            end
            ST_BRANCH: begin
                ALU_func = 4'b0001;
                PC_LdEn  = 1'b1;
                case (ir_op_s)
                    OP_B:    PC_sel = 1'b1;
                    OP_BEQ:  PC_sel = ALU_zero;
                    default: PC_sel = 1'b0;
                endcase
            end
            default: PC_Reset = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Randomized self-checking bench for multicycle_control_fsm; one instance halts on
// illegal words, the other retires them as NOPs.
module tb_multicycle_control_fsm;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = 32'h0000_0000;
    logic        ALU_zero = 1'b0;
    logic        sel = 1'b0;
    int          checks = 0;
    int          errors = 0;

    always #5 Clk = ~Clk;

    logic        h_PC_Reset, h_PC_LdEn, h_PC_sel, h_RF_WrEn, h_RF_WrDst_sel, h_RF_WrData_sel;
    logic        h_ALU_Bin_sel, h_MEM_WrEn, h_Illegal;
    logic [31:0] h_PC_Immed, h_IR, h_Immed;
    logic [3:0]  h_ALU_func;
    logic [2:0]  h_State;
    logic        n_PC_Reset, n_PC_LdEn, n_PC_sel, n_RF_WrEn, n_RF_WrDst_sel, n_RF_WrData_sel;
    logic        n_ALU_Bin_sel, n_MEM_WrEn, n_Illegal;
    logic [31:0] n_PC_Immed, n_IR, n_Immed;
    logic [3:0]  n_ALU_func;
    logic [2:0]  n_State;

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b1)) dut_h (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
        .PC_Reset(h_PC_Reset), .PC_LdEn(h_PC_LdEn), .PC_sel(h_PC_sel), .PC_Immed(h_PC_Immed),
        .IR(h_IR), .Immed(h_Immed), .RF_WrEn(h_RF_WrEn), .RF_WrDst_sel(h_RF_WrDst_sel),
        .RF_WrData_sel(h_RF_WrData_sel), .ALU_Bin_sel(h_ALU_Bin_sel), .ALU_func(h_ALU_func),
        .MEM_WrEn(h_MEM_WrEn), .Illegal(h_Illegal), .State(h_State)
    );

    multicycle_control_fsm #(.ILLEGAL_HALT(1'b0)) dut_n (
        .Clk(Clk), .Reset(Reset), .Instr(Instr), .ALU_zero(ALU_zero),
        .PC_Reset(n_PC_Reset), .PC_LdEn(n_PC_LdEn), .PC_sel(n_PC_sel), .PC_Immed(n_PC_Immed),
        .IR(n_IR), .Immed(n_Immed), .RF_WrEn(n_RF_WrEn), .RF_WrDst_sel(n_RF_WrDst_sel),
        .RF_WrData_sel(n_RF_WrData_sel), .ALU_Bin_sel(n_ALU_Bin_sel), .ALU_func(n_ALU_func),
        .MEM_WrEn(n_MEM_WrEn), .Illegal(n_Illegal), .State(n_State)
    );

    logic        o_pcr, o_ld, o_psel, o_rf, o_dst, o_data, o_bin, o_mem, o_ill;
    logic [31:0] o_pcimm, o_ir, o_imm;
    logic [3:0]  o_alu;
    logic [2:0]  o_state;

    assign o_pcr   = sel ? n_PC_Reset      : h_PC_Reset;
    assign o_ld    = sel ? n_PC_LdEn       : h_PC_LdEn;
    assign o_psel  = sel ? n_PC_sel        : h_PC_sel;
    assign o_rf    = sel ? n_RF_WrEn       : h_RF_WrEn;
    assign o_dst   = sel ? n_RF_WrDst_sel  : h_RF_WrDst_sel;
    assign o_data  = sel ? n_RF_WrData_sel : h_RF_WrData_sel;
    assign o_bin   = sel ? n_ALU_Bin_sel   : h_ALU_Bin_sel;
    assign o_mem   = sel ? n_MEM_WrEn      : h_MEM_WrEn;
    assign o_ill   = sel ? n_Illegal       : h_Illegal;
    assign o_pcimm = sel ? n_PC_Immed      : h_PC_Immed;
    assign o_ir    = sel ? n_IR            : h_IR;
    assign o_imm   = sel ? n_Immed         : h_Immed;
    assign o_alu   = sel ? n_ALU_func      : h_ALU_func;
    assign o_state = sel ? n_State         : h_State;

    // Per-instruction summary predicted from the instruction's class alone
    typedef struct packed {
        logic [7:0] cycles;
        logic [7:0] rf_wr;
        logic [7:0] mem_wr;
        logic       pc_sel;
        logic       dst;
        logic       data;
        logic [3:0] alu;
        logic       bin;
    } exp_t;

    function automatic exp_t model(input logic [31:0] ins, input logic z);
        exp_t e;
        logic [5:0] opc;
        logic [5:0] fn;
        opc = ins[31:26];
        fn  = ins[5:0];
        e = '{cycles: 8'd3, rf_wr: 8'd0, mem_wr: 8'd0, pc_sel: 1'b0, dst: 1'b0,
              data: 1'b0, alu: 4'b0001, bin: 1'b0};
        if (opc == 6'b000000 && fn[5:4] == 2'b10) begin
            e.cycles = 8'd4; e.rf_wr = 8'd1; e.dst = 1'b1; e.alu = fn[3:0];
        end else if (opc == 6'b001000) begin
            e.cycles = 8'd4; e.rf_wr = 8'd1; e.alu = 4'b0000; e.bin = 1'b1;
        end else if (opc == 6'b100011) begin
            e.cycles = 8'd5; e.rf_wr = 8'd1; e.data = 1'b1; e.alu = 4'b0000; e.bin = 1'b1;
        end else if (opc == 6'b101011) begin
            e.cycles = 8'd4; e.mem_wr = 8'd1; e.alu = 4'b0000; e.bin = 1'b1;
        end else if (opc == 6'b000100) begin
            e.pc_sel = z;
        end else if (opc == 6'b000010) begin
            e.pc_sel = 1'b1;
        end
        return e;
    endfunction

    task automatic wait_fetch();
        int guard = 0;
        while (o_state !== 3'd1 && guard < 20) begin
            @(negedge Clk);
            guard++;
        end
    endtask

    task automatic run_instr(input logic [31:0] ins, input logic z);
        exp_t        e;
        int          cyc = 0, ld_cnt = 0, rf_cnt = 0, mem_cnt = 0, overlap = 0, pcr_cnt = 0;
        logic        ld_sel = 1'b0, rf_dst = 1'b0, rf_data = 1'b0, bin = 1'b0;
        logic [3:0]  alu = 4'b0000;
        logic [31:0] sx;
        e  = model(ins, z);
        sx = {{16{ins[15]}}, ins[15:0]};
        wait_fetch();
        checks++;
        if (o_state !== 3'd1) begin
            errors++;
            $display("FAIL fetch_timeout ins=%08h: state %0d, required 1", ins, o_state);
            return;
        end
        Instr    = ins;
        ALU_zero = z;
        do begin
            if (cyc == 2) begin alu = o_alu; bin = o_bin; end
            if (o_ld === 1'b1) begin ld_cnt++; ld_sel = o_psel; end
            if (o_rf === 1'b1) begin rf_cnt++; rf_dst = o_dst; rf_data = o_data; end
            if (o_mem === 1'b1) mem_cnt++;
            if (o_rf === 1'b1 && o_mem === 1'b1) overlap++;
            if (o_pcr === 1'b1) pcr_cnt++;
            @(negedge Clk);
            cyc++;
        end while (o_state !== 3'd1 && cyc < 12);

        checks++; if (cyc !== int'(e.cycles)) begin errors++; $display("FAIL latency ins=%08h: got %0d, required %0d", ins, cyc, e.cycles); end
        checks++; if (ld_cnt !== 1) begin errors++; $display("FAIL pc_ld_pulses ins=%08h: got %0d, required 1", ins, ld_cnt); end
        checks++; if (ld_sel !== e.pc_sel) begin errors++; $display("FAIL pc_sel ins=%08h z=%0b: got %0b, required %0b", ins, z, ld_sel, e.pc_sel); end
        checks++; if (rf_cnt !== int'(e.rf_wr)) begin errors++; $display("FAIL rf_wr_count ins=%08h: got %0d, required %0d", ins, rf_cnt, e.rf_wr); end
        checks++; if (mem_cnt !== int'(e.mem_wr)) begin errors++; $display("FAIL mem_wr_count ins=%08h: got %0d, required %0d", ins, mem_cnt, e.mem_wr); end
        checks++; if (overlap !== 0 || pcr_cnt !== 0) begin errors++; $display("FAIL overlap_or_pcreset ins=%08h: got %0d/%0d, required 0/0", ins, overlap, pcr_cnt); end
        checks++; if (alu !== e.alu) begin errors++; $display("FAIL alu_func ins=%08h: got %h, required %h", ins, alu, e.alu); end
        checks++; if (bin !== e.bin) begin errors++; $display("FAIL alu_bin_sel ins=%08h: got %0b, required %0b", ins, bin, e.bin); end
        if (e.rf_wr == 8'd1) begin
            checks++; if (rf_dst !== e.dst || rf_data !== e.data) begin errors++; $display("FAIL rf_selects ins=%08h: got dst=%0b data=%0b, required dst=%0b data=%0b", ins, rf_dst, rf_data, e.dst, e.data); end
        end
        checks++; if (o_ir !== ins) begin errors++; $display("FAIL ir ins=%08h: got %08h", ins, o_ir); end
        checks++; if (o_imm !== sx) begin errors++; $display("FAIL immed ins=%08h: got %08h, required %08h", ins, o_imm, sx); end
        checks++; if (o_pcimm !== (sx << 2)) begin errors++; $display("FAIL pc_immed ins=%08h: got %08h, required %08h", ins, o_pcimm, sx << 2); end
    endtask

    task automatic test_reset();
        Instr = 32'h0043_2020;
        #2 Reset = 1'b0;
        repeat (3) @(negedge Clk);
        checks++; if (o_pcr !== 1'b1 || o_state !== 3'd0 || o_ill !== 1'b0) begin errors++; $display("FAIL reset_held: pcr=%0b state=%0d ill=%0b, required 1/0/0", o_pcr, o_state, o_ill); end
        checks++; if (o_ld !== 1'b0 || o_rf !== 1'b0 || o_mem !== 1'b0 || o_ir !== 32'h0 || o_pcimm !== 32'h0 || o_alu !== 4'h0) begin errors++; $display("FAIL reset_outputs: ld=%0b rf=%0b mem=%0b ir=%08h", o_ld, o_rf, o_mem, o_ir); end
        Reset = 1'b1;
        #1;
        checks++; if (o_state !== 3'd0 || o_pcr !== 1'b1) begin errors++; $display("FAIL init_cycle: state=%0d pcr=%0b, required 0/1", o_state, o_pcr); end
        @(negedge Clk);
        checks++; if (o_state !== 3'd1 || o_pcr !== 1'b0) begin errors++; $display("FAIL seq_fetch: state=%0d pcr=%0b, required 1/0", o_state, o_pcr); end
        @(negedge Clk);
        checks++; if (o_state !== 3'd2 || o_ill !== 1'b0) begin errors++; $display("FAIL seq_decode: state=%0d ill=%0b, required 2/0", o_state, o_ill); end
    endtask

    task automatic test_directed();
        run_instr(32'h0043_2020, 1'b0);
        run_instr(32'h8C22_0008, 1'b0);
        run_instr(32'hAC22_0008, 1'b1);
        run_instr(32'h1022_FFFF, 1'b1);
        run_instr(32'h1022_FFFF, 1'b0);
        run_instr(32'h0800_8000, 1'b0);
    endtask

    task automatic test_random();
        logic [31:0] ins;
        for (int i = 0; i < 40; i++) begin
            ins = $urandom;
            case ($urandom_range(0, 5))
                0: begin ins[31:26] = 6'b000000; ins[5:4] = 2'b10; end
                1: ins[31:26] = 6'b001000;
                2: ins[31:26] = 6'b100011;
                3: ins[31:26] = 6'b101011;
                4: ins[31:26] = 6'b000100;
                default: ins[31:26] = 6'b000010;
            endcase
            run_instr(ins, 1'($urandom_range(0, 1)));
        end
    endtask

    task automatic test_illegal();
        int ld_cnt = 0, bad_state = 0;
        sel = 1'b1;
        run_instr(32'hFC00_0000, 1'b1);
        checks++; if (h_State !== 3'd7 || h_Illegal !== 1'b1) begin errors++; $display("FAIL halt_entry: state=%0d ill=%0b, required 7/1", h_State, h_Illegal); end
        for (int i = 0; i < 20; i++) begin
            @(negedge Clk);
            if (h_PC_LdEn === 1'b1) ld_cnt++;
            if (h_State !== 3'd7 || h_Illegal !== 1'b1) bad_state++;
        end
        checks++; if (ld_cnt !== 0 || bad_state !== 0) begin errors++; $display("FAIL halt_hold: ld pulses=%0d bad cycles=%0d, required 0/0", ld_cnt, bad_state); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid_lw();
        int rf_cnt = 0, guard = 0;
        Reset = 1'b0;
        repeat (2) @(negedge Clk);
        Instr = 32'h8C22_0010;
        Reset = 1'b1;
        while (o_state !== 3'd4 && guard < 10) begin
            if (o_rf === 1'b1) rf_cnt++;
            @(negedge Clk);
            guard++;
        end
        checks++; if (o_state !== 3'd4) begin errors++; $display("FAIL reach_mem: state=%0d, required 4", o_state); end
        Reset = 1'b0;
        #1;
        checks++; if (o_state !== 3'd0 || o_pcr !== 1'b1 || o_ir !== 32'h0 || o_imm !== 32'h0 || o_bin !== 1'b0 || o_alu !== 4'h0) begin errors++; $display("FAIL async_reset: state=%0d pcr=%0b ir=%08h bin=%0b alu=%h", o_state, o_pcr, o_ir, o_bin, o_alu); end
        repeat (2) begin
            @(negedge Clk);
            if (o_rf === 1'b1 || o_mem === 1'b1 || o_ld === 1'b1) rf_cnt++;
        end
        checks++; if (rf_cnt !== 0) begin errors++; $display("FAIL dropped_write: writes seen=%0d, required 0", rf_cnt); end
        Instr = 32'h2022_FFF0;
        Reset = 1'b1;
        #1;
        checks++; if (o_state !== 3'd0 || o_pcr !== 1'b1) begin errors++; $display("FAIL restart_init: state=%0d pcr=%0b, required 0/1", o_state, o_pcr); end
        run_instr(32'h2022_FFF0, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_illegal();
        test_reset_mid_lw();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
